// File: rtl/uart_v2_rx.sv
// 8N1 UART receiver: 4x oversampled rx_line into a one-deep holding register with sticky error flags.
// Latency: byte visible 38*SAMPLE_DIV cycles after START entry (stop sample at mid-bit).
// Backpressure: none on the line; a byte completing while rx_full=1 without rx_ack is dropped and flagged.
module uart_v2_rx #(
    parameter int unsigned SAMPLE_DIV = 109
) (
    input  logic       sysclk,
    input  logic       sysreset,
    input  logic       rx_line,
    input  logic       rx_ack,
    input  logic       err_clear,
    output logic [7:0] rx_data,
    output logic       rx_full,
    output logic       rx_busy,
    output logic       rx_frame_err,
    output logic       rx_overrun
);

    localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t      state;
    logic [1:0]  sync_q;
    logic        rxs;
    logic [15:0] div_cnt;
    logic        tick;
    logic [1:0]  phase;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_q;

    assign rxs  = sync_q[1];
    assign tick = (div_cnt == DIV_LAST);

    // Synchronizer resets to idle-high so reset release never looks like a start edge.
    always_ff @(posedge sysclk or negedge sysreset) begin
        if (!sysreset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_line};
        end
    end

    always_ff @(posedge sysclk or negedge sysreset) begin
        if (!sysreset) begin
            state        <= IDLE;
            div_cnt      <= '0;
            phase        <= '0;
            bit_idx      <= '0;
            shift_q      <= '0;
            rx_data      <= '0;
            rx_full      <= 1'b0;
            rx_busy      <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            // Clears and acks first; any set or delivery below in the same cycle overrides them.
            if (err_clear) begin
                rx_frame_err <= 1'b0;
                rx_overrun   <= 1'b0;
            end
            if (rx_ack && rx_full) begin
                rx_full <= 1'b0;
            end

            case (state)
                IDLE: begin
                    div_cnt <= '0;
                    phase   <= '0;
                    if (!rxs) begin
                        state   <= START;
                        rx_busy <= 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    div_cnt <= '0;
                    if (rxs) begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end
                end
                default: begin
                    div_cnt <= tick ? 16'd0 : div_cnt + 16'd1;
                    if (tick) begin
                        phase <= phase + 2'd1;
                        case (state)
                            START: begin
                                if (phase == 2'd1) begin
                                    phase <= '0;
                                    if (rxs) begin
                                        state   <= IDLE;
                                        rx_busy <= 1'b0;
                                    end else begin
                                        state   <= DATA;
                                        bit_idx <= '0;
                                    end
                                end
                            end
                            DATA: begin
                                if (phase == 2'd3) begin
                                    shift_q <= {rxs, shift_q[7:1]};
                                    bit_idx <= bit_idx + 3'd1;
                                    if (bit_idx == 3'd7) begin
                                        state <= STOP;
                                    end
                                end
                            end
                            STOP: begin
                                if (phase == 2'd3) begin
                                    if (rxs) begin
                                        state   <= IDLE;
                                        rx_busy <= 1'b0;
                                        if (!rx_full || rx_ack) begin
                                            rx_data <= shift_q;
                                            rx_full <= 1'b1;
                                        end else begin
                                            rx_overrun <= 1'b1;
                                        end
                                    end else begin
                                        // Break or bad stop: drop the byte and wait out the low line.
                                        state        <= WAIT_HIGH;
                                        rx_frame_err <= 1'b1;
                                    end
                                end
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_v2_rx.sv
// Directed bench for uart_v2_rx at SAMPLE_DIV=4 (16 cycles per bit) with a byte scoreboard.
module tb_uart_v2_rx;

    logic       sysclk = 1'b0;
    logic       sysreset = 1'b0;
    logic       rx_line = 1'b1;
    logic       rx_ack = 1'b0;
    logic       err_clear = 1'b0;
    logic [7:0] rx_data;
    logic       rx_full;
    logic       rx_busy;
    logic       rx_frame_err;
    logic       rx_overrun;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    uart_v2_rx #(.SAMPLE_DIV(4)) dut (
        .sysclk       (sysclk),
        .sysreset     (sysreset),
        .rx_line      (rx_line),
        .rx_ack       (rx_ack),
        .err_clear    (err_clear),
        .rx_data      (rx_data),
        .rx_full      (rx_full),
        .rx_busy      (rx_busy),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_pop(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, observed rx_data 0x%0h", tag, rx_data);
        end else begin
            e = exp_q.pop_front();
            check(tag, {8'h00, rx_data}, {8'h00, e});
        end
    endtask

    task automatic all_zero(input string tag);
        check(tag, {8'h00, rx_data}, 16'h0000);
        check(tag, {12'h000, rx_full, rx_busy, rx_frame_err, rx_overrun}, 16'h0000);
    endtask

    // Called on a falling clock edge; returns 160 cycles later with the stop level still driven.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx_line = 1'b0;
        repeat (16) @(negedge sysclk);
        for (int i = 0; i < 8; i++) begin
            rx_line = b[i];
            repeat (16) @(negedge sysclk);
        end
        rx_line = stop;
        repeat (16) @(negedge sysclk);
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        @(negedge sysclk);
        rx_ack = 1'b0;
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        @(negedge sysclk);
        err_clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with the line toggling.
        for (int i = 0; i < 5; i++) begin
            @(negedge sysclk);
            rx_line = ~rx_line;
            #1 all_zero("reset_hold");
        end
        @(negedge sysclk);
        rx_line  = 1'b1;
        sysreset = 1'b1;
        repeat (50) @(negedge sysclk);
        check("idle_busy", {15'h0, rx_busy}, 16'h0);

        // Normal byte with exact delivery timing.
        exp_q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (2) @(negedge sysclk);
                check("busy_before_start", {15'h0, rx_busy}, 16'h0);
                @(negedge sysclk);
                check("busy_at_start", {15'h0, rx_busy}, 16'h1);
                repeat (151) @(negedge sysclk);
                check("full_before_stop", {15'h0, rx_full}, 16'h0);
                @(negedge sysclk);
                check("full_after_stop", {15'h0, rx_full}, 16'h1);
                check("busy_after_stop", {15'h0, rx_busy}, 16'h0);
                check_pop("data_a5");
            end
        join
        pulse_ack();
        check("full_after_ack", {15'h0, rx_full}, 16'h0);
        check("data_kept_after_ack", {8'h00, rx_data}, 16'h00A5);

        // Glitch of four cycles is rejected at the start-bit confirm.
        repeat (10) @(negedge sysclk);
        rx_line = 1'b0;
        repeat (3) @(negedge sysclk);
        check("glitch_busy", {15'h0, rx_busy}, 16'h1);
        @(negedge sysclk);
        rx_line = 1'b1;
        repeat (7) @(negedge sysclk);
        check("glitch_busy_drop", {15'h0, rx_busy}, 16'h0);
        check("glitch_full", {15'h0, rx_full}, 16'h0);
        repeat (10) @(negedge sysclk);
        exp_q.push_back(8'h00);
        send_frame(8'h00, 1'b1);
        check_pop("data_00");
        check("full_00", {15'h0, rx_full}, 16'h1);
        pulse_ack();

        // Bad stop bit followed by a held break.
        repeat (10) @(negedge sysclk);
        send_frame(8'h3C, 1'b0);
        repeat (200) @(negedge sysclk);
        check("break_frame_err", {15'h0, rx_frame_err}, 16'h1);
        check("break_full", {15'h0, rx_full}, 16'h0);
        check("break_busy", {15'h0, rx_busy}, 16'h1);
        check("break_data_kept", {8'h00, rx_data}, 16'h0000);
        rx_line = 1'b1;
        repeat (4) @(negedge sysclk);
        check("break_release_busy", {15'h0, rx_busy}, 16'h0);
        pulse_clear();
        check("frame_err_cleared", {15'h0, rx_frame_err}, 16'h0);

        // Overrun: second byte dropped while the first is unread.
        repeat (10) @(negedge sysclk);
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        check_pop("overrun_data");
        check("overrun_full", {15'h0, rx_full}, 16'h1);
        check("overrun_flag", {15'h0, rx_overrun}, 16'h1);
        pulse_ack();
        check("overrun_ack_full", {15'h0, rx_full}, 16'h0);
        pulse_clear();
        check("overrun_cleared", {15'h0, rx_overrun}, 16'h0);

        // Ack coinciding with the stop tick lets the next byte in.
        exp_q.push_back(8'h33);
        send_frame(8'h33, 1'b1);
        check_pop("data_33");
        exp_q.push_back(8'h44);
        fork
            send_frame(8'h44, 1'b1);
            begin
                repeat (154) @(negedge sysclk);
                rx_ack = 1'b1;
                @(negedge sysclk);
                rx_ack = 1'b0;
            end
        join
        check_pop("data_44_sim_ack");
        check("sim_ack_full", {15'h0, rx_full}, 16'h1);
        check("sim_ack_no_overrun", {15'h0, rx_overrun}, 16'h0);

        // Asynchronous reset during data bit 4, then a clean frame.
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (88) @(negedge sysclk);
                sysreset = 1'b0;
                #1 all_zero("midframe_reset");
                repeat (4) @(negedge sysclk);
                sysreset = 1'b1;
            end
        join
        repeat (20) @(negedge sysclk);
        check("post_reset_idle", {15'h0, rx_busy}, 16'h0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        check_pop("data_5a");
        check("full_5a", {15'h0, rx_full}, 16'h1);
        check("flags_5a", {14'h0, rx_frame_err, rx_overrun}, 16'h0);
        check("scoreboard_drained", 16'(exp_q.size()), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_v2_rx.md
# uart_v2_rx

Serial receiver that is the upstream counterpart of the `uart_v2_tx` transmitter on the target MCU's UART. It oversamples the asynchronous input line at 4x the bit rate from `sysclk`, frames 8N1 characters, and presents each received byte in a one-deep holding register. The MCU reads that register through an `r[]`/`r_read` register-file slot and acknowledges it. Framing errors and overruns are reported as sticky flags.

## Interface
- `SAMPLE_DIV`, default 109: `sysclk` cycles per sample tick; four ticks make one bit (50 MHz / 109 / 4 ≈ 115 200 bps). Legal range 2..65535.
- `sysclk`  in  1  system clock; all state changes on its rising edge.
- `sysreset`  in  1  reset, asynchronous assert, active-low (0 = reset).
- `rx_line`  in  1  asynchronous serial input; idle high.
- `rx_ack`  in  1  one-cycle pulse when the MCU reads `rx_data` (driven from `r_read` of the data slot).
- `err_clear`  in  1  one-cycle pulse; clears both sticky error flags.
- `rx_data`  out  8  last delivered byte.
- `rx_full`  out  1  holding register contains an unread byte.
- `rx_busy`  out  1  a frame is in progress (state ≠ IDLE).
- `rx_frame_err`  out  1  sticky; a stop bit was sampled low.
- `rx_overrun`  out  1  sticky; a byte completed while `rx_full`=1 and was dropped.

## Operation
- `rx_line` passes through a 2-flop synchronizer whose flops reset to 1. All logic uses the synchronized value `rxs`.
- Tick divider: a 16-bit counter runs 0..SAMPLE_DIV-1. `tick` is high for one cycle when the count equals SAMPLE_DIV-1, then the counter wraps to 0. In IDLE the counter is held at 0.
- Frame FSM, sampling only on `tick` except in IDLE:
  - IDLE: when `rxs`=0, go to START with the divider and the phase counter cleared.
  - START: on the 2nd tick (mid start bit), if `rxs`=0 go to DATA with bit index 0; if `rxs`=1 it was a glitch, so return to IDLE.
  - DATA: every 4th tick, shift `rxs` in LSB-first. After bit 7, go to STOP.
  - STOP: 4 ticks later, sample `rxs`. If 1, deliver the byte and go to IDLE. If 0, set `rx_frame_err`, discard the byte, and go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rxs`=1, evaluated every cycle, then go to IDLE. A held break line therefore never produces further frames.
- Delivery, on the cycle the stop sample is taken:
  - If `rx_full`=0, or `rx_ack` is high in that same cycle: load `rx_data` with the shift register and set `rx_full`=1.
  - Otherwise: set `rx_overrun`=1. `rx_data` and `rx_full` are unchanged.
- `rx_ack` with `rx_full`=1 and no simultaneous delivery clears `rx_full`. `rx_ack` with `rx_full`=0 is ignored. `rx_data` is never cleared by `rx_ack`.
- `err_clear` clears both sticky flags. If a flag is set in the same cycle as `err_clear`, the set wins.
- Reset, including mid-frame: all outputs go to 0, the FSM goes to IDLE, the shift register, divider and phase counters clear, and the synchronizer flops go to 1. The partial frame is lost. The first falling edge after release starts a fresh frame.

## Timing
- Let T = SAMPLE_DIV. Edge detection latency is 2 cycles (synchronizer) from an `rx_line` fall to `rxs`=0. START is entered in the following cycle, which is cycle 0 of the frame.
- Sample ticks occur at frame cycles:
  - start bit confirm: 2T-1
  - data bit i: (2+4(i+1))T-1
  - stop bit: 38T-1
- `rx_full`, `rx_data`, `rx_frame_err` and `rx_overrun` update on the edge after the stop tick, i.e. they are visible at frame cycle 38T.
- `rx_busy` rises at frame cycle 0. It falls the cycle after the stop tick, or, in WAIT_HIGH, one cycle after `rxs` returns high.
- Back-to-back frames: the next start edge is accepted the cycle after returning to IDLE. With the stop sample at mid-bit, this gives about half a bit of margin.
- `rx_full` clears on the edge after `rx_ack`. Zero-wait reads are supported.

## Test plan
- Reset: hold `sysreset`=0 for 5 cycles with `rx_line` toggling → all outputs 0 throughout; after release and 50 idle cycles, `rx_busy` is still 0.
- Normal byte (SAMPLE_DIV=4, 16 cycles/bit): send 0xA5 8N1 → `rx_data`=0xA5 and `rx_full`=1 at 152 cycles after START entry; pulse `rx_ack` → `rx_full`=0 next cycle; `rx_data` stays 0xA5.
- Glitch: drive `rx_line` low for 4 cycles, then high → `rx_busy` pulses and returns to 0 by cycle 8; `rx_full`=0; then a subsequent 0x00 frame is received correctly.
- Framing/break: send 0x3C with stop bit 0, then hold low 200 cycles → `rx_frame_err`=1, `rx_full`=0, `rx_busy`=1 until the line rises; `err_clear` → flag 0.
- Overrun and simultaneous ack:
  - Send 0x11 without ack, then 0x22 → `rx_data`=0x11, `rx_overrun`=1.
  - Ack, then send 0x33 with a second 0x44 frame whose `rx_ack` coincides with the stop tick → `rx_data`=0x44, `rx_full`=1, no new overrun.
- Reset mid-frame: assert reset during data bit 4 of 0xFF → outputs 0 immediately (asynchronous); after release, 0x5A is received intact with no error flags.
